// File: rtl/mmm_pkg.sv
// -----------------------------------------------------------------------------
// mmm_pkg
//   Shared definitions for the radix-2 Montgomery multiplier:
//   - default operand / modulus width
//   - FSM state encodings and the state enum used by mmm_ctrl
// -----------------------------------------------------------------------------
package mmm_pkg;

  localparam int MMM_WIDTH_DEFAULT = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_CORR = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_CORR = ST_CORR,
    S_FIN  = ST_FIN
  } mmm_state_e;

endpackage

// File: rtl/mmm_ctrl.sv
// -----------------------------------------------------------------------------
// mmm_ctrl
//   Sequencer and iteration counter for the Montgomery multiplier.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; result registers hold the last answer
//   CALC   | one radix-2 step per enabled edge, WIDTH steps in total
//   CORR   | final conditional subtraction of M
//   FIN    | done pulse; also reached directly when M is even
//
// Ports
//   clk, rstb    clock, synchronous active-low reset
//   en           global enable, 0 freezes every register
//   start        request, only honoured in IDLE
//   m_odd        bit 0 of the incoming modulus
//   accept       IDLE accepts a request this edge
//   calc_step    datapath performs one iteration this edge
//   corr_step    datapath registers the corrected result this edge
//   busy, done   status outputs
// -----------------------------------------------------------------------------
module mmm_ctrl
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  logic start,
  input  logic m_odd,
  output logic accept,
  output logic calc_step,
  output logic corr_step,
  output logic busy,
  output logic done
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mmm_state_e       state_q;
  mmm_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_hold_q;
  logic             cnt_wrap;

  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign accept    = en && start && (state_q == S_IDLE);
  assign calc_step = en && (state_q == S_CALC);
  assign corr_step = en && (state_q == S_CORR);
  assign busy      = (state_q == S_CALC) || (state_q == S_CORR);
  // A rejected (even) modulus lands in FIN straight from IDLE; err_hold_q
  // keeps done low for that first FIN cycle so the error is announced one
  // cycle after the accepting edge.
  assign done      = (state_q == S_FIN) && !err_hold_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = m_odd ? S_CALC : S_FIN;
      S_CALC:  if (cnt_wrap) state_d = S_CORR;
      S_CORR:  state_d = S_FIN;
      S_FIN:   if (!err_hold_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_hold_q <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      err_hold_q <= accept && !m_odd;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmm_unit_param.sv
// -----------------------------------------------------------------------------
// mmm_unit_param
//   Radix-2 Montgomery modular multiplier: r_out = A*B*2^-WIDTH mod M.
//   Bits of A are consumed LSB first, one per CALC cycle; a final
//   conditional subtraction brings the accumulator below M.
//
// Ports
//   clk, rstb             clock, synchronous active-low reset
//   en                    global enable, 0 freezes all state
//   start                 request a multiplication (IDLE only)
//   a_in, b_in, m_in      operands and modulus, sampled on accept
//   r_out                 registered result, valid from done to next accept
//   busy                  high in CALC and CORR
//   done                  one-cycle completion pulse
//   err                   set when an even modulus was rejected
// -----------------------------------------------------------------------------
module mmm_unit_param
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = WIDTH + 2;

  logic             accept;
  logic             calc_step;
  logic             corr_step;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   mb_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] r_q;
  logic             err_q;

  logic             a_bit;
  logic             q_bit;
  logic [AW-1:0]    sel_add;
  logic [AW:0]      acc_sum;
  logic [AW-1:0]    acc_next;
  logic [AW-1:0]    m_ext;
  logic [WIDTH-1:0] corr_res;

  mmm_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .start     (start),
    .m_odd     (m_in[0]),
    .accept    (accept),
    .calc_step (calc_step),
    .corr_step (corr_step),
    .busy      (busy),
    .done      (done)
  );

  // A is shifted right each step, so the current bit is always a_sh[0].
  assign a_bit = a_sh[0];
  assign q_bit = acc_q[0] ^ (a_bit & b_q[0]);

  always_comb begin
    sel_add = '0;
    unique case ({a_bit, q_bit})
      2'b00:   sel_add = '0;
      2'b10:   sel_add = {2'b00, b_q};
      2'b01:   sel_add = {2'b00, m_q};
      default: sel_add = {1'b0, mb_q};
    endcase
  end

  // One extra bit on the sum so nothing is lost before the halving.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, sel_add};
  assign acc_next = AW'(acc_sum >> 1);

  // The accumulator stays below 2M, so the low WIDTH bits of the
  // difference are the full corrected result.
  assign m_ext    = {2'b00, m_q};
  assign corr_res = (acc_q >= m_ext) ? (acc_q[WIDTH-1:0] - m_q) : acc_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      a_sh  <= '0;
      b_q   <= '0;
      m_q   <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_in;
      b_q   <= b_in;
      m_q   <= m_in;
      mb_q  <= {1'b0, b_in} + {1'b0, m_in};
      acc_q <= '0;
      err_q <= ~m_in[0];
      if (!m_in[0]) begin
        r_q <= '0;
      end
    end else if (calc_step) begin
      acc_q <= acc_next;
      a_sh  <= a_sh >> 1;
    end else if (corr_step) begin
      r_q <= corr_res;
    end
  end

  assign r_out = r_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mmm_unit_param.sv
module tb_mmm_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb;
  logic       en;

  logic       start4;
  logic [3:0] a4, b4, m4, r4;
  logic       busy4, done4, err4;

  logic       start10;
  logic [9:0] a10, b10, m10, r10;
  logic       busy10, done10, err10;

  mmm_unit_param #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rstb  (rstb),
    .en    (en),
    .start (start4),
    .a_in  (a4),
    .b_in  (b4),
    .m_in  (m4),
    .r_out (r4),
    .busy  (busy4),
    .done  (done4),
    .err   (err4)
  );

  mmm_unit_param #(.WIDTH(10)) dut10 (
    .clk   (clk),
    .rstb  (rstb),
    .en    (en),
    .start (start10),
    .a_in  (a10),
    .b_in  (b10),
    .m_in  (m10),
    .r_out (r10),
    .busy  (busy10),
    .done  (done10),
    .err   (err10)
  );

  int checks = 0;
  int errors = 0;

  bit          sel10;
  logic [31:0] cur_r;
  logic        cur_busy, cur_done, cur_err;

  always_comb begin
    if (sel10) begin
      cur_r    = 32'(r10);
      cur_busy = busy10;
      cur_done = done10;
      cur_err  = err10;
    end else begin
      cur_r    = 32'(r4);
      cur_busy = busy4;
      cur_done = done4;
      cur_err  = err4;
    end
  end

  typedef struct {
    bit          w10;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [31:0] r;
    logic        err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input bit w10, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] m);
    logic [31:0] av, bv, mv;
    av = a; bv = b; mv = m;
    if (w10) begin
      a10 = av[9:0]; b10 = bv[9:0]; m10 = mv[9:0]; start10 = 1'b1;
    end else begin
      a4 = av[3:0]; b4 = bv[3:0]; m4 = mv[3:0]; start4 = 1'b1;
    end
  endtask

  // Starts one operation at the current negedge and follows it to done.
  task automatic run_op(input bit w10, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m, input logic [31:0] r_exp,
                        input logic err_exp, input string name);
    int lat;
    int exp_lat;
    logic busy_seen;
    sel10   = w10;
    exp_lat = err_exp ? 1 : (w10 ? 11 : 5);
    drive_start(w10, a, b, m);
    @(negedge clk);
    start4 = 1'b0; start10 = 1'b0;
    chk($sformatf("%s_busy", name), 32'(cur_busy), 32'(!err_exp));
    busy_seen = cur_busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cur_done === 1'b1) begin
        lat = k;
        break;
      end
      if (cur_busy === 1'b1) busy_seen = 1'b1;
    end
    chk($sformatf("%s_lat", name), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_r", name), cur_r, r_exp);
    chk($sformatf("%s_err", name), 32'(cur_err), 32'(err_exp));
    if (err_exp) chk($sformatf("%s_busy_seen", name), 32'(busy_seen), 32'd0);
    @(negedge clk);
    chk($sformatf("%s_pulse", name), 32'(cur_done), 32'd0);
    chk($sformatf("%s_hold", name), cur_r, r_exp);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 32'd5,    32'd7,    32'd13,   32'd3,   1'b0};
    vecs[1]  = '{1'b0, 32'd12,   32'd12,   32'd13,   32'd9,   1'b0};
    vecs[2]  = '{1'b0, 32'd5,    32'd7,    32'd12,   32'd0,   1'b1};
    vecs[3]  = '{1'b0, 32'd14,   32'd14,   32'd15,   32'd1,   1'b0};
    vecs[4]  = '{1'b0, 32'd8,    32'd8,    32'd9,    32'd4,   1'b0};
    vecs[5]  = '{1'b0, 32'd10,   32'd10,   32'd11,   32'd9,   1'b0};
    vecs[6]  = '{1'b0, 32'd3,    32'd0,    32'd13,   32'd0,   1'b0};
    vecs[7]  = '{1'b1, 32'd1,    32'd5,    32'd1019, 32'd1,   1'b0};
    vecs[8]  = '{1'b1, 32'd0,    32'd5,    32'd1019, 32'd0,   1'b0};
    vecs[9]  = '{1'b1, 32'd1000, 32'd3,    32'd1019, 32'd600, 1'b0};
    vecs[10] = '{1'b1, 32'd3,    32'd5,    32'd1018, 32'd0,   1'b1};
    vecs[11] = '{1'b1, 32'd204,  32'd1,    32'd1019, 32'd856, 1'b0};
    vecs[12] = '{1'b1, 32'd1018, 32'd1018, 32'd1019, 32'd204, 1'b0};
    vecs[13] = '{1'b1, 32'd2,    32'd5,    32'd1019, 32'd2,   1'b0};

    rstb = 1'b0; en = 1'b0; sel10 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
    start10 = 1'b0; a10 = '0; b10 = '0; m10 = '0;

    // Reset state, applied with en low.
    repeat (2) @(negedge clk);
    chk("rst_r4", 32'(r4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_err4", 32'(err4), 32'd0);
    chk("rst_r10", 32'(r10), 32'd0);
    chk("rst_busy10", 32'(busy10), 32'd0);
    chk("rst_done10", 32'(done10), 32'd0);
    chk("rst_err10", 32'(err10), 32'd0);
    rstb = 1'b1; en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].w10, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].err,
             $sformatf("vec%0d", i));
    end

    // en low for three edges mid-CALC, plus a start pulse while busy.
    sel10 = 1'b1;
    drive_start(1'b1, 32'd1000, 32'd3, 32'd1019);
    @(negedge clk);
    start10 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cur_done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 2) drive_start(1'b1, 32'd5, 32'd5, 32'd1019);
      if (k == 3) begin
        start10 = 1'b0;
        en = 1'b0;
      end
      if (k == 5) chk("engap_frozen_busy", 32'(cur_busy), 32'd1);
      if (k == 6) en = 1'b1;
    end
    chk("engap_lat", 32'(lat), 32'd14);
    chk("engap_r", cur_r, 32'd600);
    @(negedge clk);

    // done stays high while en is low, then drops on the next enabled edge.
    sel10 = 1'b0;
    drive_start(1'b0, 32'd12, 32'd12, 32'd13);
    @(negedge clk);
    start4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cur_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("dhold_lat", 32'(lat), 32'd5);
    en = 1'b0;
    @(negedge clk);
    chk("dhold_done1", 32'(cur_done), 32'd1);
    @(negedge clk);
    chk("dhold_done2", 32'(cur_done), 32'd1);
    chk("dhold_r", cur_r, 32'd9);
    en = 1'b1;
    @(negedge clk);
    chk("dhold_released", 32'(cur_done), 32'd0);

    // Reset during CALC aborts without a done pulse.
    sel10 = 1'b1;
    drive_start(1'b1, 32'd204, 32'd1, 32'd1019);
    @(negedge clk);
    start10 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy10), 32'd1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    chk("abort_r", 32'(r10), 32'd0);
    chk("abort_busy", 32'(busy10), 32'd0);
    chk("abort_done", 32'(done10), 32'd0);
    chk("abort_err", 32'(err10), 32'd0);
    lat = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done10 === 1'b1 || busy10 === 1'b1) lat = lat + 1;
    end
    chk("abort_quiet", 32'(lat), 32'd0);
    run_op(1'b1, 32'd1000, 32'd3, 32'd1019, 32'd600, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmm_unit_param.md
MMM_UNIT_PARAM -- requirements
Module: mmm_unit_param

Interface
REQ-001 SHALL have parameter WIDTH, default 10, operand/modulus width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-005 SHALL have port start  input  1  request a multiplication; sampled in IDLE only.
REQ-006 SHALL have ports a_in, b_in, m_in  input  WIDTH each  operands A, B and modulus M; sampled on the accepting edge only.
REQ-007 SHALL have port r_out  output  WIDTH  registered result R = A*B*2^-WIDTH mod M.
REQ-008 SHALL have port busy  output  1  high from accepting edge until done is asserted.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse; r_out/err valid from that cycle until the next accept.
REQ-010 SHALL have port err  output  1  registered; set when an even modulus was rejected.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC, CORR, FIN.
REQ-012 In IDLE with en=1 and start=1 (edge t0), it SHALL latch A, B, M, precompute MB=B+M (WIDTH+1 bits), clear accumulator, clear iteration counter, clear err, and go to CALC.
REQ-013 If m_in[0]=0 at accept, it SHALL instead set err=1, set r_out=0, and go directly to FIN.
REQ-014 Each CALC edge with en=1 SHALL perform one radix-2 step, LSB of A first: q=(R[0] xor (a_i and B[0])); R=(R + sel)>>1, with sel = 0, B, M or MB chosen by (a_i,q).
REQ-015 The accumulator SHALL be WIDTH+2 bits; no carry shall be lost.
REQ-016 After exactly WIDTH CALC steps (counter wraps at WIDTH-1), the FSM SHALL go to CORR.
REQ-017 CORR SHALL register r_out = (R>=M) ? R-M : R, truncated to WIDTH bits, and go to FIN.
REQ-018 FIN SHALL assert done=1 for one cycle and return to IDLE; done SHALL be 0 in all other states.
REQ-019 With en held 1, done SHALL be high during the cycle following edge t0+WIDTH+1 (error path: following t0+1).
REQ-020 busy SHALL be 1 in CALC and CORR, 0 in IDLE and FIN.
REQ-021 start while busy or in FIN SHALL be ignored; operands SHALL not be re-sampled.
REQ-022 en=0 SHALL hold state, counter, accumulator and all outputs unchanged, including a pending done, which then remains high until the next edge with en=1.
REQ-023 r_out and err SHALL hold their last values in IDLE until the next accept.
REQ-024 Results SHALL be correct for odd M with A<M and B<M; other operand values yield an unspecified r_out but a normal done.

Reset
REQ-025 rstb=0 at a rising edge SHALL force IDLE, and r_out=0, busy=0, done=0, err=0, counter=0, accumulator=0, regardless of en.
REQ-026 Reset mid-operation SHALL abort without any done pulse; the next accept SHALL start a fresh computation.

Structure
REQ-027 Package mmm_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-028 The FSM/counter SHALL be the sub-module mmm_ctrl; the datapath (operand registers, MB, accumulator, correction subtractor) SHALL stay in mmm_unit_param.
REQ-029 The counter width SHALL be clog2(WIDTH).

Verification
REQ-030 WIDTH=4, M=13, A=5, B=7, start pulse -> done 5 cycles after accept, r_out=3, err=0.
REQ-031 WIDTH=4, M=13, A=12, B=12 -> r_out=9 (exercises the CORR subtraction path).
REQ-032 WIDTH=10, M=1019, A=1, B=5 -> done 11 cycles after accept, r_out=1; A=0 -> r_out=0.
REQ-033 WIDTH=10, M=1018 -> err=1, r_out=0, done 1 cycle after accept, busy never high.
REQ-034 WIDTH=10, M=1019, en low for 3 cycles mid-CALC -> done delayed by exactly 3 cycles, same r_out; start pulses during busy are ignored.
REQ-035 rstb low for one edge during CALC -> IDLE, all outputs 0, no done; a following start gives the correct result.
